// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 encodings, FSM states, byte-enable
// patterns and the request legality check.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_funct3_e;

    typedef logic [2:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE   = 3'd0;
    localparam lsu_state_t ST_REQ    = 3'd1;
    localparam lsu_state_t ST_WAIT_R = 3'd2;
    localparam lsu_state_t ST_RESP   = 3'd3;
    localparam lsu_state_t ST_ERR    = 3'd4;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Misaligned access, unused encoding, or unsigned-width store.
    function automatic logic lsu_illegal(input logic wren, input logic [2:0] funct3,
                                         input logic [1:0] a);
        logic bad;
        case (funct3)
            LSU_B:   bad = 1'b0;
            LSU_BU:  bad = wren;
            LSU_H:   bad = a[0];
            LSU_HU:  bad = a[0] | wren;
            LSU_W:   bad = |a;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: shifts the addressed lane down and sign/zero-extends; combinational.
// No flow control; result is consumed in the cycle rdata is valid.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  funct3,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {a, 3'b000};
        case (funct3)
            LSU_B:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            LSU_H:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
            LSU_BU:  ld_data = {24'h0, shifted[7:0]};
            LSU_HU:  ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between EX and data memory; accept->req 1 cycle, store done N+2, load N+3 min.
// o_lsu_ready is low while a transaction is in flight; REQ/WAIT_R stall indefinitely on memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_lsu_valid,
    output logic              o_lsu_ready,
    input  logic              i_lsu_wren,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic [31:0]       i_lsu_wdata,
    input  logic [2:0]        i_lsu_funct3,
    output logic [31:0]       o_ld_data,
    output logic              o_ld_valid,
    output logic              o_st_done,
    output logic              o_lsu_err,
    output logic              o_mem_req,
    input  logic              i_mem_gnt,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata
);

    lsu_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic              wren_q;
    logic [31:0]       wdata_q;
    logic [31:0]       ld_data_q;
    logic              st_done_q;
    logic              accept;
    logic [3:0]        be_raw;
    logic [31:0]       align_dat;

    // RESP behaves like IDLE so a new request can be taken alongside o_ld_valid.
    assign o_lsu_ready = (state == ST_IDLE) || (state == ST_RESP);
    assign accept      = o_lsu_ready & i_lsu_valid;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            addr_q   <= '0;
            funct3_q <= 3'b000;
            wren_q   <= 1'b0;
            wdata_q  <= 32'h0;
        end else if (accept) begin
            addr_q   <= i_lsu_addr;
            funct3_q <= i_lsu_funct3;
            wren_q   <= i_lsu_wren;
            wdata_q  <= i_lsu_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_IDLE;
            st_done_q <= 1'b0;
            ld_data_q <= 32'h0;
        end else begin
            st_done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (i_lsu_valid)
                        state <= lsu_illegal(i_lsu_wren, i_lsu_funct3, i_lsu_addr[1:0])
                                 ? ST_ERR : ST_REQ;
                    else
                        state <= ST_IDLE;
                end
                ST_ERR: state <= ST_IDLE;
                ST_REQ: begin
                    if (i_mem_gnt) begin
                        if (wren_q) begin
                            state     <= ST_IDLE;
                            st_done_q <= 1'b1;
                        end else begin
                            state <= ST_WAIT_R;
                        end
                    end
                end
                ST_WAIT_R: begin
                    if (i_mem_rvalid) begin
                        ld_data_q <= align_dat;
                        state     <= ST_RESP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    lsu_load_align u_align (
        .rdata   (i_mem_rdata),
        .a       (addr_q[1:0]),
        .funct3  (funct3_q),
        .ld_data (align_dat)
    );

    always_comb begin
        case (funct3_q)
            LSU_B, LSU_BU: be_raw = BE_BYTE << addr_q[1:0];
            LSU_H, LSU_HU: be_raw = BE_HALF << {addr_q[1], 1'b0};
            default:       be_raw = BE_WORD;
        endcase
        case (funct3_q)
            LSU_B:   o_mem_wdata = {4{wdata_q[7:0]}};
            LSU_H:   o_mem_wdata = {2{wdata_q[15:0]}};
            default: o_mem_wdata = wdata_q;
        endcase
    end

    assign o_mem_req  = (state == ST_REQ);
    assign o_mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign o_mem_we   = o_mem_req & wren_q;
    assign o_mem_be   = o_mem_req ? be_raw : 4'b0000;
    assign o_lsu_err  = (state == ST_ERR);
    assign o_ld_valid = (state == ST_RESP);
    assign o_st_done  = st_done_q;
    assign o_ld_data  = ld_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level model of access sizes,
// alignment and extension, with a per-cycle compare process.
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_lsu_valid = 1'b0;
    logic        o_lsu_ready;
    logic        i_lsu_wren = 1'b0;
    logic [31:0] i_lsu_addr = 32'h0;
    logic [31:0] i_lsu_wdata = 32'h0;
    logic [2:0]  i_lsu_funct3 = 3'b000;
    logic [31:0] o_ld_data;
    logic        o_ld_valid;
    logic        o_st_done;
    logic        o_lsu_err;
    logic        o_mem_req;
    logic        i_mem_gnt = 1'b0;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = 32'h0;

    always #5 i_clk = ~i_clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_lsu_valid  (i_lsu_valid),
        .o_lsu_ready  (o_lsu_ready),
        .i_lsu_wren   (i_lsu_wren),
        .i_lsu_addr   (i_lsu_addr),
        .i_lsu_wdata  (i_lsu_wdata),
        .i_lsu_funct3 (i_lsu_funct3),
        .o_ld_data    (o_ld_data),
        .o_ld_valid   (o_ld_valid),
        .o_st_done    (o_st_done),
        .o_lsu_err    (o_lsu_err),
        .o_mem_req    (o_mem_req),
        .i_mem_gnt    (i_mem_gnt),
        .o_mem_addr   (o_mem_addr),
        .o_mem_we     (o_mem_we),
        .o_mem_be     (o_mem_be),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    logic        chk_en = 1'b0;
    logic        exp_ready, exp_req, exp_err, exp_st, exp_ldv, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic        lit_en = 1'b0;
    logic [31:0] lit_exp = 32'h0;
    logic        pend_st = 1'b0;
    logic        pend_ld = 1'b0;
    logic [31:0] pend_val = 32'h0;
    logic [31:0] last_ld = 32'h0;

    // ---------------- reference model: sizes in bytes, plain arithmetic ----------------
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic m_legal(input logic wr, input logic [2:0] f3, input logic [31:0] ad);
        int n;
        n = m_size(f3);
        if (n == 0) return 1'b0;
        if (wr && (f3 == 3'd4 || f3 == 3'd5)) return 1'b0;
        return (ad % 32'(n)) == 32'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] ad);
        int v;
        v = ((1 << m_size(f3)) - 1) << int'(ad % 32'd4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (m_size(f3))
            1:       return 32'(wd[7:0]) * 32'h0101_0101;
            2:       return 32'(wd[15:0]) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] ad,
                                         input logic [31:0] rd);
        int          bits;
        logic [63:0] v;
        logic [63:0] mask;
        bits = 8 * m_size(f3);
        v    = {32'h0, rd} >> (8 * int'(ad % 32'd4));
        mask = (64'd1 << bits) - 64'd1;
        v    = v & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && v[bits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        chk("pin_be_lb13",   32'(m_be(3'd0, 32'h13)), 32'h8);
        chk("pin_be_sh22",   32'(m_be(3'd1, 32'h22)), 32'hC);
        chk("pin_wd_sh",     m_wdata(3'd1, 32'h1234_ABCD), 32'hABCD_ABCD);
        chk("pin_ld_lb",     m_ld(3'd0, 32'h13, 32'h80FF_0000), 32'hFFFF_FF80);
        chk("pin_ld_lbu",    m_ld(3'd4, 32'h13, 32'h80FF_0000), 32'h0000_0080);
        chk("pin_legal_lw6", 32'(m_legal(1'b0, 3'd2, 32'h06)), 32'h0);
        forever begin
            @(negedge i_clk);
            if (chk_en) begin
                chk("ready",    32'(o_lsu_ready), 32'(exp_ready));
                chk("mem_req",  32'(o_mem_req),   32'(exp_req));
                chk("lsu_err",  32'(o_lsu_err),   32'(exp_err));
                chk("st_done",  32'(o_st_done),   32'(exp_st));
                chk("ld_valid", 32'(o_ld_valid),  32'(exp_ldv));
                chk("ld_data",  o_ld_data,        exp_ld);
                if (exp_req) begin
                    chk("mem_addr", o_mem_addr,     exp_addr);
                    chk("mem_we",   32'(o_mem_we),  32'(exp_we));
                    chk("mem_be",   32'(o_mem_be),  32'(exp_be));
                    if (exp_we) chk("mem_wdata", o_mem_wdata, exp_wdata);
                end
                if (lit_en) chk("lit_ld_data", o_ld_data, lit_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic begin_cycle();
        i_lsu_valid  = 1'b0;
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        exp_ready = 1'b1;
        exp_req   = 1'b0;
        exp_err   = 1'b0;
        exp_we    = 1'b0;
        exp_be    = 4'h0;
        exp_addr  = 32'h0;
        exp_wdata = 32'h0;
        exp_st    = pend_st;
        exp_ldv   = pend_ld;
        if (pend_ld) last_ld = pend_val;
        exp_ld  = last_ld;
        pend_st = 1'b0;
        pend_ld = 1'b0;
    endtask

    task automatic end_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            begin_cycle();
            i_mem_rvalid = 1'($urandom_range(0, 1));
            i_mem_gnt    = 1'($urandom_range(0, 1));
            i_mem_rdata  = $urandom;
            end_cycle();
        end
    endtask

    task automatic resp_lit(input logic [31:0] val);
        begin_cycle();
        lit_en  = 1'b1;
        lit_exp = val;
        end_cycle();
        lit_en = 1'b0;
    endtask

    task automatic txn(input logic wr, input logic [2:0] f3, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int gd, input int rvd, input logic rst_mid);
        begin_cycle();
        i_lsu_valid  = 1'b1;
        i_lsu_wren   = wr;
        i_lsu_funct3 = f3;
        i_lsu_addr   = ad;
        i_lsu_wdata  = wd;
        i_mem_gnt    = 1'($urandom_range(0, 1));
        i_mem_rvalid = 1'($urandom_range(0, 1));
        end_cycle();
        if (!m_legal(wr, f3, ad)) begin
            begin_cycle();
            exp_ready = 1'b0;
            exp_err   = 1'b1;
            end_cycle();
            return;
        end
        for (int i = 0; i <= gd; i++) begin
            begin_cycle();
            exp_ready = 1'b0;
            exp_req   = 1'b1;
            exp_addr  = ad & ~32'h3;
            exp_we    = wr;
            exp_be    = m_be(f3, ad);
            exp_wdata = m_wdata(f3, wd);
            i_mem_gnt    = (i == gd);
            i_mem_rvalid = 1'($urandom_range(0, 1));
            i_lsu_valid  = 1'($urandom_range(0, 1));
            i_lsu_wren   = 1'($urandom_range(0, 1));
            i_lsu_funct3 = 3'($urandom_range(0, 7));
            i_lsu_addr   = $urandom;
            i_lsu_wdata  = $urandom;
            end_cycle();
        end
        if (wr) begin
            pend_st = 1'b1;
            return;
        end
        if (rst_mid) begin
            begin_cycle();
            i_reset      = 1'b0;
            last_ld      = 32'h0;
            exp_ld       = 32'h0;
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = rd;
            end_cycle();
            begin_cycle();
            i_reset      = 1'b1;
            i_mem_rvalid = 1'b1;
            end_cycle();
            return;
        end
        for (int i = 0; i <= rvd; i++) begin
            begin_cycle();
            exp_ready    = 1'b0;
            i_mem_rvalid = (i == rvd);
            i_mem_rdata  = (i == rvd) ? rd : $urandom;
            i_mem_gnt    = 1'($urandom_range(0, 1));
            i_lsu_valid  = 1'($urandom_range(0, 1));
            end_cycle();
        end
        pend_ld  = 1'b1;
        pend_val = m_ld(f3, ad, rd);
    endtask

    initial begin
        begin_cycle();
        chk_en = 1'b1;
        end_cycle();
        for (int i = 0; i < 2; i++) begin
            begin_cycle();
            end_cycle();
        end
        i_reset = 1'b1;
        idle_cyc(2);

        txn(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        resp_lit(32'hDEAD_BEEF);
        txn(1'b0, 3'd0, 32'h13, 32'h0, 32'h80FF_0000, 0, 1, 1'b0);
        resp_lit(32'hFFFF_FF80);
        txn(1'b0, 3'd4, 32'h13, 32'h0, 32'h80FF_0000, 1, 0, 1'b0);
        resp_lit(32'h0000_0080);
        txn(1'b1, 3'd1, 32'h22, 32'h1234_ABCD, 32'h0, 3, 0, 1'b0);
        idle_cyc(1);
        txn(1'b0, 3'd2, 32'h06, 32'h0, 32'h0, 0, 0, 1'b0);
        txn(1'b1, 3'd1, 32'h01, 32'h5A5A_5A5A, 32'h0, 0, 0, 1'b0);
        txn(1'b0, 3'd3, 32'h00, 32'h0, 32'h0, 0, 0, 1'b0);
        idle_cyc(1);
        txn(1'b0, 3'd2, 32'h40, 32'h0, 32'h5555_AAAA, 0, 1, 1'b1);
        idle_cyc(3);
        txn(1'b1, 3'd2, 32'h80, 32'hCAFE_F00D, 32'h0, 0, 0, 1'b0);
        txn(1'b0, 3'd5, 32'h82, 32'h0, 32'hBEEF_1234, 1, 0, 1'b0);
        resp_lit(32'h0000_BEEF);
        idle_cyc(2);

        for (int k = 0; k < 400; k++) begin
            logic        wr;
            logic [2:0]  f3;
            logic [31:0] ad;
            int          n;
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            ad = $urandom;
            n  = m_size(f3);
            if (n != 0 && $urandom_range(0, 3) != 0) ad = ad & ~32'(n - 1);
            txn(wr, f3, ad, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                (k % 50 == 25) && !wr);
            idle_cyc($urandom_range(0, 2));
        end
        idle_cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
